// File: rtl/mem_march_sequencer.sv
// March C- memory BIST sequencer issuing one memory operation per clock.
// Defining MEM_MARCH_DIAG_EN adds first-fail capture ports FAIL_ADDR/FAIL_ELEM/FAIL_DATA.
module mem_march_sequencer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              BIST_CLK,
  input  logic              BIST_RESETN,
  input  logic              MBISTPG_EN,
  input  logic              REDUCED_ADDRESS_COUNT,
  input  logic              BIST_ALGO_MODE0,
  input  logic [DATA_W-1:0] A_DOUT,
  output logic              A_MEN,
  output logic              A_WEN,
  output logic              A_REN,
  output logic [ADDR_W-1:0] A_ADDR,
  output logic [DATA_W-1:0] A_DIN,
  output logic              BIST_ON,
  output logic              MBISTPG_DONE,
  output logic              MBISTPG_GO
`ifdef MEM_MARCH_DIAG_EN
  ,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [2:0]        FAIL_ELEM,
  output logic [DATA_W-1:0] FAIL_DATA
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_16   = ADDR_W'(4'd15);

  // Background word: all-0/all-1, or 0x55../0xAA.. checkerboard when mode is set.
  function automatic logic [DATA_W-1:0] background(input logic mode, input logic ones);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W; i++) begin
      w[i] = mode ? ((i % 2 == 0) ^ ones) : ones;
    end
    return w;
  endfunction

  function automatic logic op_is_write(input logic [2:0] elem, input logic sub);
    case (elem)
      3'd0:    op_is_write = 1'b1;
      3'd5:    op_is_write = 1'b0;
      default: op_is_write = sub;
    endcase
  endfunction

  function automatic logic op_ones(input logic [2:0] elem, input logic sub);
    case (elem)
      3'd1, 3'd3: op_ones = sub;
      3'd2, 3'd4: op_ones = ~sub;
      default:    op_ones = 1'b0;
    endcase
  endfunction

  function automatic logic is_down(input logic [2:0] elem);
    return (elem == 3'd3) || (elem == 3'd4);
  endfunction

  state_t              state_q, state_d;
  logic                reduced_q, reduced_d, mode_q, mode_d;
  logic [2:0]          elem_q, elem_d;
  logic                sub_q, sub_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                on_q, on_d, done_q, done_d, go_q, go_d;
  logic                chk_vld_q, chk_vld_d;
  logic [DATA_W-1:0]   chk_exp_q, chk_exp_d;
  logic [ADDR_W-1:0]   addr_max;
  logic                elem_end, sub_last, miscmp;
`ifdef MEM_MARCH_DIAG_EN
  logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d, fail_addr_q, fail_addr_d;
  logic [2:0]          chk_elem_q, chk_elem_d, fail_elem_q, fail_elem_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
`endif

  // Next-state, next-operation and compare logic.
  always_comb begin
    state_d   = state_q;
    reduced_d = reduced_q;
    mode_d    = mode_q;
    elem_d    = elem_q;
    sub_d     = sub_q;
    addr_d    = addr_q;
    din_d     = din_q;
    on_d      = on_q;
    done_d    = done_q;
    go_d      = go_q;
    men_d     = 1'b0;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    chk_vld_d = 1'b0;
    chk_exp_d = chk_exp_q;
`ifdef MEM_MARCH_DIAG_EN
    chk_addr_d  = chk_addr_q;
    chk_elem_d  = chk_elem_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
`endif
    addr_max = reduced_q ? ADDR_16 : {ADDR_W{1'b1}};
    elem_end = is_down(elem_q) ? (addr_q == ADDR_ZERO) : (addr_q == addr_max);
    sub_last = (elem_q == 3'd0) || (elem_q == 3'd5) || sub_q;
    miscmp   = chk_vld_q && (A_DOUT != chk_exp_q);

    case (state_q)
      IDLE: begin
        if (MBISTPG_EN) begin
          state_d   = RUN;
          reduced_d = REDUCED_ADDRESS_COUNT;
          mode_d    = BIST_ALGO_MODE0;
          elem_d    = 3'd0;
          sub_d     = 1'b0;
          addr_d    = ADDR_ZERO;
          men_d     = 1'b1;
          wen_d     = 1'b1;
          din_d     = background(BIST_ALGO_MODE0, 1'b0);
          on_d      = 1'b1;
          go_d      = 1'b1;
          done_d    = 1'b0;
`ifdef MEM_MARCH_DIAG_EN
          fail_addr_d = ADDR_ZERO;
          fail_elem_d = 3'd0;
          fail_data_d = {DATA_W{1'b0}};
`endif
        end else begin
          addr_d = ADDR_ZERO;
          din_d  = {DATA_W{1'b0}};
          on_d   = 1'b0;
          done_d = 1'b0;
        end
      end
      RUN, DRAIN: begin
        if (!MBISTPG_EN) begin
          state_d = IDLE;
          addr_d  = ADDR_ZERO;
          din_d   = {DATA_W{1'b0}};
          on_d    = 1'b0;
          done_d  = 1'b0;
          go_d    = 1'b0;
        end else if (state_q == DRAIN) begin
          state_d = DONE;
          on_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          // The read issued this cycle is checked when its data returns next cycle.
          chk_vld_d = ren_q;
          chk_exp_d = din_q;
`ifdef MEM_MARCH_DIAG_EN
          chk_addr_d = addr_q;
          chk_elem_d = elem_q;
`endif
          if ((elem_q == 3'd5) && elem_end) begin
            state_d = DRAIN;
            addr_d  = ADDR_ZERO;
            din_d   = {DATA_W{1'b0}};
          end else begin
            if (!sub_last) begin
              sub_d = 1'b1;
            end else begin
              sub_d = 1'b0;
              if (elem_end) begin
                elem_d = elem_q + 3'd1;
                addr_d = is_down(elem_d) ? addr_max : ADDR_ZERO;
              end else begin
                addr_d = is_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
              end
            end
            men_d = 1'b1;
            wen_d = op_is_write(elem_d, sub_d);
            ren_d = ~wen_d;
            din_d = background(mode_q, op_ones(elem_d, sub_d));
          end
        end
      end
      DONE: begin
        if (!MBISTPG_EN) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (miscmp && MBISTPG_EN) begin
      go_d = 1'b0;
`ifdef MEM_MARCH_DIAG_EN
      if (go_q) begin
        fail_addr_d = chk_addr_q;
        fail_elem_d = chk_elem_q;
        fail_data_d = A_DOUT;
      end else begin
        fail_addr_d = fail_addr_q;
      end
`endif
    end else begin
      go_d = go_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge BIST_CLK) begin
    if (!BIST_RESETN) begin
      state_q   <= IDLE;
      reduced_q <= 1'b0;
      mode_q    <= 1'b0;
      elem_q    <= 3'd0;
      sub_q     <= 1'b0;
      addr_q    <= ADDR_ZERO;
      men_q     <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      din_q     <= {DATA_W{1'b0}};
      on_q      <= 1'b0;
      done_q    <= 1'b0;
      go_q      <= 1'b0;
      chk_vld_q <= 1'b0;
      chk_exp_q <= {DATA_W{1'b0}};
`ifdef MEM_MARCH_DIAG_EN
      chk_addr_q  <= ADDR_ZERO;
      chk_elem_q  <= 3'd0;
      fail_addr_q <= ADDR_ZERO;
      fail_elem_q <= 3'd0;
      fail_data_q <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      reduced_q <= reduced_d;
      mode_q    <= mode_d;
      elem_q    <= elem_d;
      sub_q     <= sub_d;
      addr_q    <= addr_d;
      men_q     <= men_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      din_q     <= din_d;
      on_q      <= on_d;
      done_q    <= done_d;
      go_q      <= go_d;
      chk_vld_q <= chk_vld_d;
      chk_exp_q <= chk_exp_d;
`ifdef MEM_MARCH_DIAG_EN
      chk_addr_q  <= chk_addr_d;
      chk_elem_q  <= chk_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
`endif
    end
  end

  assign A_MEN        = men_q;
  assign A_WEN        = wen_q;
  assign A_REN        = ren_q;
  assign A_ADDR       = addr_q;
  assign A_DIN        = din_q;
  assign BIST_ON      = on_q;
  assign MBISTPG_DONE = done_q;
  assign MBISTPG_GO   = go_q;
`ifdef MEM_MARCH_DIAG_EN
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_ELEM = fail_elem_q;
  assign FAIL_DATA = fail_data_q;
`endif

endmodule

// File: tb/tb_mem_march_sequencer.sv
// Scoreboard bench for mem_march_sequencer: a March C- op-list model feeds a queue
// that a forked monitor checks against every memory access.
module tb_mem_march_sequencer;
  localparam int AW = 13;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, en, red, mode;
  logic [DW-1:0] dout = '0;
  logic          men, wen, ren, on, done, go;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
`ifdef MEM_MARCH_DIAG_EN
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
`endif

  mem_march_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .BIST_CLK(clk), .BIST_RESETN(rstn), .MBISTPG_EN(en),
    .REDUCED_ADDRESS_COUNT(red), .BIST_ALGO_MODE0(mode), .A_DOUT(dout),
    .A_MEN(men), .A_WEN(wen), .A_REN(ren), .A_ADDR(addr), .A_DIN(din),
    .BIST_ON(on), .MBISTPG_DONE(done), .MBISTPG_GO(go)
`ifdef MEM_MARCH_DIAG_EN
    , .FAIL_ADDR(fail_addr), .FAIL_ELEM(fail_elem), .FAIL_DATA(fail_data)
`endif
  );

  typedef struct {
    bit            w;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  op_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Memory with an optional stuck-at-1 bit; read data appears the cycle after A_REN.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mdl [0:(1<<AW)-1];
  bit fault_en = 1'b0;
  int fault_addr = 0;
  int fault_bit = 0;

  function automatic logic [DW-1:0] fmask(input int a);
    if (fault_en && a == fault_addr) return DW'(1) << fault_bit;
    return '0;
  endfunction

  always @(posedge clk) begin
    if (men && wen) mem[addr] <= din | fmask(int'(addr));
    if (men && ren) dout <= mem[addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    op_t e;
    forever begin
      @(negedge clk);
      if (men === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_op", {wen, ren, addr}, 64'h0);
        end else begin
          e = sb.pop_front();
          chk("op_kind", {wen, ren}, e.w ? 64'h2 : 64'h1);
          chk("op_addr", addr, e.addr);
          if (e.w) chk("op_wdata", din, e.data);
        end
      end
    end
  endtask

  // March C- reference: element table walked with plain loops over a faulty memory image.
  task automatic build(input bit r, input bit m, output bit eg, output logic [AW-1:0] efa,
                       output logic [2:0] efe, output logic [DW-1:0] efd);
    int n, a;
    bit has, w;
    logic [DW-1:0] d0, d1, d;
    n  = r ? 16 : (1 << AW);
    d0 = m ? 32'h5555_5555 : 32'h0;
    d1 = ~d0;
    eg = 1'b1; efa = '0; efe = '0; efd = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < n; i++) begin
        a = (e == 3 || e == 4) ? (n - 1 - i) : i;
        for (int s = 0; s < 2; s++) begin
          case (e)
            0:       begin has = (s == 0); w = 1'b1;     d = d0; end
            1, 3:    begin has = 1'b1;     w = (s == 1); d = (s == 1) ? d1 : d0; end
            2, 4:    begin has = 1'b1;     w = (s == 1); d = (s == 1) ? d0 : d1; end
            default: begin has = (s == 0); w = 1'b0;     d = d0; end
          endcase
          if (has) begin
            sb.push_back('{w: w, addr: AW'(a), data: d});
            if (w) begin
              mdl[a] = d | fmask(a);
            end else if (mdl[a] != d && eg) begin
              eg = 1'b0; efa = AW'(a); efe = 3'(e); efd = mdl[a];
            end
          end
        end
      end
    end
  endtask

  // kind: 0 run to completion, 1 drop EN at op stop_at, 2 assert reset at op stop_at.
  task automatic run_one(input bit r, input bit m, input bit fen, input int fa, input int fb,
                         input int stop_at, input int kind);
    bit eg, seen;
    logic [AW-1:0] efa;
    logic [2:0] efe;
    logic [DW-1:0] efd;
    int n, k;
    fault_en = fen; fault_addr = fa; fault_bit = fb;
    build(r, m, eg, efa, efe, efd);
    n = r ? 16 : (1 << AW);
    if (kind != 0) while (sb.size() > stop_at) void'(sb.pop_back());
    @(negedge clk);
    en = 1'b1; red = r; mode = m;
    seen = 1'b0;
    for (k = 1; k <= 10 * n + 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("on_at_entry", on, 1);
        chk("go_at_entry", go, 1);
        red = 1'($urandom); mode = 1'($urandom);
      end
      if (kind != 0 && k == stop_at) break;
      if (done) begin seen = 1'b1; break; end
    end
    if (kind == 1) begin
      en = 1'b0;
      @(negedge clk);
      chk("abort_outputs", {men, on, done, go}, 0);
      repeat (3) @(negedge clk);
      chk("abort_ops_left", sb.size(), 0);
    end else if (kind == 2) begin
      rstn = 1'b0;
      @(negedge clk);
      chk("midrun_reset_outputs", {men, wen, ren, addr, din, on, done, go}, 0);
      @(negedge clk);
      chk("reset_overrides_en", {men, on}, 0);
      en = 1'b0; rstn = 1'b1;
      @(negedge clk);
      chk("reset_ops_left", sb.size(), 0);
    end else begin
      chk("done_seen", seen, 1);
      chk("done_cycle", k, 10 * n + 2);
      chk("on_in_done", on, 0);
      chk("go_final", go, eg);
`ifdef MEM_MARCH_DIAG_EN
      chk("fail_addr", fail_addr, efa);
      chk("fail_elem", fail_elem, efe);
      chk("fail_data", fail_data, efd);
`endif
      chk("ops_left", sb.size(), 0);
      @(negedge clk);
      chk("done_held", done, 1);
      en = 1'b0;
      @(negedge clk);
      chk("idle_after_done", {done, on}, 0);
    end
    sb.delete();
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; red = 1'b0; mode = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("reset_outputs", {men, wen, ren, addr, din, on, done, go}, 0);
    en = 1'b0; rstn = 1'b1;
    @(negedge clk);
    run_one(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    run_one(1'b1, 1'b0, 1'b1, 5, 0, 0, 0);
    run_one(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    run_one(1'b1, 1'b0, 1'b0, 0, 0, 40, 1);
    run_one(1'b1, 1'($urandom), 1'b0, 0, 0, 55, 2);
    run_one(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    for (int t = 0; t < 6; t++) begin
      run_one(1'b1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 31)), 0, 0);
    end
    run_one(1'b0, 1'($urandom), 1'b0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
